// File: rtl/gtech_fifo4x4_pkg.sv
// Shared sizing constants and types for the 4x4 first-word-fall-through FIFO.
// The top and its pointer/count controller both import this package.
package gtech_fifo4x4_pkg;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_WIDTH = 4;
   localparam int PTR_W      = 2;
   localparam int CNT_W      = 3;

   typedef logic [FIFO_WIDTH-1:0] word_t;
   typedef logic [PTR_W-1:0]      ptr_t;
   typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/gtech_fifo4x4_ctl.sv
// Pointer, occupancy and sticky-flag control for the 4x4 FIFO.
// Flags decode from the registered count, never from the pointers.
module gtech_fifo4x4_ctl
   import gtech_fifo4x4_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic we,
   input  logic re,
   output ptr_t wp,
   output ptr_t rp,
   output cnt_t cnt,
   output logic empty,
   output logic full,
   output logic push,
   output logic ovf,
   output logic unf
);

   logic pop;

   assign empty = (cnt == cnt_t'(0));
   assign full  = (cnt == cnt_t'(FIFO_DEPTH));

   // A pop on the same edge frees the slot the push lands in.
   assign push = we & (~full | re);
   assign pop  = re & ~empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         ovf <= ovf | (we & full & ~re);
         unf <= unf | (re & empty);
      end
   end

endmodule

// File: rtl/gtech_fifo4x4.sv
// 4-entry x 4-bit FWFT FIFO: storage array and output muxing.
// Head data is forced to zero while empty, so stale entries never show.
module gtech_fifo4x4
   import gtech_fifo4x4_pkg::*;
(
   input  logic       CP,
   input  logic       CD,
   input  logic       D0,
   input  logic       D1,
   input  logic       D2,
   input  logic       D3,
   input  logic       WE,
   input  logic       RE,
   output logic       Q0,
   output logic       Q1,
   output logic       Q2,
   output logic       Q3,
   output logic       QN0,
   output logic       QN1,
   output logic       QN2,
   output logic       QN3,
   output logic       EMPTY,
   output logic       FULL,
   output logic [2:0] CNT,
   output logic       OVF,
   output logic       UNF
);

   word_t mem [FIFO_DEPTH];
   word_t din;
   word_t head;
   ptr_t  wp;
   ptr_t  rp;
   cnt_t  cnt;
   logic  push;

   assign din = {D3, D2, D1, D0};

   gtech_fifo4x4_ctl u_ctl (
      .clk   (CP),
      .rst_n (CD),
      .we    (WE),
      .re    (RE),
      .wp    (wp),
      .rp    (rp),
      .cnt   (cnt),
      .empty (EMPTY),
      .full  (FULL),
      .push  (push),
      .ovf   (OVF),
      .unf   (UNF)
   );

   // Array is deliberately not cleared; reset only drops the write.
   always_ff @(posedge CP) begin
      if (CD && push)
         mem[wp] <= din;
   end

   assign head = EMPTY ? '0 : mem[rp];
   assign CNT  = cnt;

   assign Q0  = head[0];
   assign Q1  = head[1];
   assign Q2  = head[2];
   assign Q3  = head[3];
   assign QN0 = ~head[0];
   assign QN1 = ~head[1];
   assign QN2 = ~head[2];
   assign QN3 = ~head[3];

endmodule

// File: tb/tb_gtech_fifo4x4.sv
// Bench for gtech_fifo4x4: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_gtech_fifo4x4;

   logic       CP = 1'b0;
   logic       CD;
   logic       WE;
   logic       RE;
   logic [3:0] d;
   logic       Q0, Q1, Q2, Q3;
   logic       QN0, QN1, QN2, QN3;
   logic       EMPTY, FULL, OVF, UNF;
   logic [2:0] CNT;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] mq[$];
   bit         m_ovf;
   bit         m_unf;

   gtech_fifo4x4 dut (
      .CP(CP), .CD(CD),
      .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
      .WE(WE), .RE(RE),
      .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
      .QN0(QN0), .QN1(QN1), .QN2(QN2), .QN3(QN3),
      .EMPTY(EMPTY), .FULL(FULL), .CNT(CNT),
      .OVF(OVF), .UNF(UNF)
   );

   always #5 CP = ~CP;

   function automatic void model_edge(bit cd, bit we, bit re,
                                      logic [3:0] dv);
      bit emp, ful, do_pop, do_push;
      if (!cd) begin
         mq.delete();
         m_ovf = 0;
         m_unf = 0;
         return;
      end
      emp     = (mq.size() == 0);
      ful     = (mq.size() == 4);
      do_pop  = re && !emp;
      do_push = we && (!ful || re);
      if (re && emp) m_unf = 1;
      if (we && ful && !re) m_ovf = 1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(dv);
   endfunction

   function automatic logic [14:0] exp_vec();
      logic [3:0] h;
      h = (mq.size() != 0) ? mq[0] : 4'h0;
      return {3'(mq.size()), mq.size() == 0, mq.size() == 4,
              h, ~h, m_ovf, m_unf};
   endfunction

   function automatic logic [14:0] got_vec();
      return {CNT, EMPTY, FULL, Q3, Q2, Q1, Q0,
              QN3, QN2, QN1, QN0, OVF, UNF};
   endfunction

   function automatic logic [3:0] q_now();
      return {Q3, Q2, Q1, Q0};
   endfunction

   task automatic step(input bit cd, input bit we, input bit re,
                       input logic [3:0] dv);
      CD = cd; WE = we; RE = re; d = dv;
      @(posedge CP);
      model_edge(cd, we, re, dv);
      #1;
   endtask

   task automatic fill();
      step(0, 0, 0, 4'h0);
      step(1, 1, 0, 4'h3);
      step(1, 1, 0, 4'h5);
      step(1, 1, 0, 4'hA);
      step(1, 1, 0, 4'hC);
   endtask

   task automatic test_reset();
      step(0, 1, 1, 4'h7);
      step(0, 1, 1, 4'h7);
      n_tests++;
      if (got_vec() !== {3'd0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got %h want %h", got_vec(),
                  {3'd0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0});
      end
   endtask

   task automatic test_fill_drain();
      logic [3:0] want [4] = '{4'h5, 4'hA, 4'hC, 4'h0};
      fill();
      n_tests++;
      if (got_vec() !== exp_vec() || CNT !== 3'd4 || FULL !== 1'b1 ||
          q_now() !== 4'h3 || {QN3, QN2, QN1, QN0} !== 4'hC) begin
         n_fail++;
         $display("FAIL fill: got %h want %h", got_vec(), exp_vec());
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 4'h0);
         n_tests++;
         if (got_vec() !== exp_vec() || q_now() !== want[i]) begin
            n_fail++;
            $display("FAIL drain%0d: got %h want %h q %h", i,
                     got_vec(), exp_vec(), want[i]);
         end
      end
      n_tests++;
      if (EMPTY !== 1'b1 || UNF !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_end: empty %b unf %b want 1 0", EMPTY, UNF);
      end
   endtask

   task automatic test_full_push_pop();
      fill();
      step(1, 1, 1, 4'h9);
      n_tests++;
      if (got_vec() !== exp_vec() || CNT !== 3'd4 || q_now() !== 4'h5) begin
         n_fail++;
         $display("FAIL full_pp: got %h want %h", got_vec(), exp_vec());
      end
      for (int i = 0; i < 3; i++) step(1, 0, 1, 4'h0);
      n_tests++;
      if (got_vec() !== exp_vec() || q_now() !== 4'h9) begin
         n_fail++;
         $display("FAIL full_pp_tail: got %h want %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_empty_push_pop();
      step(0, 0, 0, 4'h0);
      step(1, 1, 1, 4'h6);
      n_tests++;
      if (got_vec() !== exp_vec() || CNT !== 3'd1 || q_now() !== 4'h6 ||
          UNF !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_pp: got %h want %h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_ovf_unf();
      fill();
      step(1, 1, 0, 4'hF);
      n_tests++;
      if (got_vec() !== exp_vec() || OVF !== 1'b1 || UNF !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf: got %h want %h", got_vec(), exp_vec());
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 4'h0);
         n_tests++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ovf_contents%0d: got %h want %h", i,
                     got_vec(), exp_vec());
         end
      end
      step(1, 0, 1, 4'h0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 4'h0);
      n_tests++;
      if (got_vec() !== exp_vec() || OVF !== 1'b1 || UNF !== 1'b1) begin
         n_fail++;
         $display("FAIL sticky: got %h want %h", got_vec(), exp_vec());
      end
      step(0, 0, 0, 4'h0);
      n_tests++;
      if (OVF !== 1'b0 || UNF !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clr: ovf %b unf %b want 0 0", OVF, UNF);
      end
   endtask

   task automatic test_reset_dominates();
      step(0, 0, 0, 4'h0);
      step(1, 1, 0, 4'h4);
      step(1, 1, 0, 4'h8);
      step(0, 1, 1, 4'hE);
      n_tests++;
      if (got_vec() !== {3'd0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_dom: got %h want %h", got_vec(),
                  {3'd0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0});
      end
   endtask

   task automatic test_wrap();
      logic [3:0] seen[$];
      bit         over = 0;
      step(0, 0, 0, 4'h0);
      step(1, 1, 0, 4'h1);
      step(1, 1, 0, 4'h2);
      for (int v = 3; v <= 8; v++) begin
         seen.push_back(q_now());
         step(1, 1, 1, 4'(v));
         if (CNT > 3'd4) over = 1;
      end
      for (int i = 0; i < 2; i++) begin
         seen.push_back(q_now());
         step(1, 0, 1, 4'h0);
         if (CNT > 3'd4) over = 1;
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (seen[i] !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL wrap_order%0d: got %h want %h", i,
                     seen[i], 4'(i + 1));
         end
      end
      n_tests++;
      if (over || got_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL wrap_end: over %b got %h want %h", over,
                  got_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int bad = 0;
      step(0, 0, 0, 4'h0);
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(49) != 0, $urandom_range(1) == 1,
              $urandom_range(2) == 0, 4'($urandom));
         n_tests++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL random%0d: got %h want %h", i,
                        got_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   initial begin
      CD = 1'b0; WE = 1'b0; RE = 1'b0; d = 4'h0;
      test_reset();
      test_fill_drain();
      test_full_push_pop();
      test_empty_push_pop();
      test_ovf_unf();
      test_reset_dominates();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
